// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer and its output FIFO.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'h3F;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries; head is presented combinationally.
module fetch_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_eff, pop_eff;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign dout     = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign pop_eff  = pop & ~empty & ~flush;
  assign push_eff = push & ~flush & (~full | pop_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, reads InstructionMemory and queues {pc, inst} for decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int               ADDR_W      = 8,
  parameter int               DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int               FIFO_DEPTH  = 2,
  parameter logic [5:0]       HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] inst_address,
  input  logic [DATA_W-1:0] read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic              halted
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              busy_q, halted_q;

  logic              redirect_take, flush, push, pop, is_halt;
  logic              fifo_empty, fifo_full_unused;
  logic [CNT_W-1:0]  fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_dout;

  assign redirect_take = redirect_valid & (state_q != ST_IDLE);
  assign flush         = redirect_take | start;
  assign pop           = out_valid & out_ready;
  assign push          = (state_q == ST_RUN) & ~flush &
                         ((fifo_count < CNT_W'(FIFO_DEPTH)) | pop);
  assign is_halt       = (read_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);

  assign inst_address  = pc_q;
  assign out_valid     = ~fifo_empty;
  assign out_pc        = fifo_dout[ADDR_W+DATA_W-1:DATA_W];
  assign out_inst      = fifo_dout[DATA_W-1:0];
  assign busy          = busy_q;
  assign halted        = halted_q;

  // Redirect outranks start, which outranks a normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_take) begin
      state_d = ST_RUN;
      pc_d    = redirect_pc;
    end else if (start) begin
      state_d = ST_RUN;
      pc_d    = RESET_PC;
    end else if (push) begin
      pc_d = pc_q + 1'b1;
      if (is_halt) state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      busy_q   <= (state_d == ST_RUN);
      halted_q <= (state_d == ST_HALT);
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({pc_q, read_data}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full_unused),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational 256x32 instruction memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  inst_address;
  logic [31:0] read_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [7:0]  out_pc;
  logic        busy;
  logic        halted;

  logic [31:0] mem [256];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign read_data = mem[inst_address];

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_address   (inst_address),
    .read_data      (read_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .busy           (busy),
    .halted         (halted)
  );

  // Advance n rising edges, leaving time 1 unit past the last edge for sampling.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [39:0] observed,
                             input logic [39:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {6'h00, 26'(i)};
    rst_n          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    out_ready      = 1'b0;

    #12;
    checkOutput("rst_valid", 40'(out_valid), 40'd0);
    checkOutput("rst_busy", 40'(busy), 40'd0);
    checkOutput("rst_halted", 40'(halted), 40'd0);
    checkOutput("rst_addr", 40'(inst_address), 40'h00);
    rst_n = 1'b1;
    applyStimulus(1);

    // Redirect is ignored while idle.
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    applyStimulus(1);
    redirect_valid = 1'b0;
    checkOutput("idle_redir_busy", 40'(busy), 40'd0);
    checkOutput("idle_redir_addr", 40'(inst_address), 40'h00);

    $display("[TB] streaming");
    start     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    checkOutput("start_busy", 40'(busy), 40'd1);
    checkOutput("start_valid0", 40'(out_valid), 40'd0);
    checkOutput("start_addr", 40'(inst_address), 40'h00);
    applyStimulus(1);
    checkOutput("stream_valid0", 40'(out_valid), 40'd1);
    checkOutput("stream_pc0", 40'(out_pc), 40'h00);
    checkOutput("stream_inst0", 40'(out_inst), 40'h0000_0000);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1);
      checkOutput("stream_valid", 40'(out_valid), 40'd1);
      checkOutput("stream_pc", 40'(out_pc), 40'(i));
      checkOutput("stream_inst", 40'(out_inst), 40'(i));
    end

    $display("[TB] backpressure");
    out_ready = 1'b0;
    start     = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(5);
    checkOutput("bp_valid", 40'(out_valid), 40'd1);
    checkOutput("bp_head", 40'(out_pc), 40'h00);
    checkOutput("bp_pc_hold", 40'(inst_address), 40'h02);
    out_ready = 1'b1;
    applyStimulus(1);
    checkOutput("bp_rel1", 40'(out_pc), 40'h01);
    applyStimulus(1);
    checkOutput("bp_rel2", 40'(out_pc), 40'h02);
    checkOutput("bp_rel2_inst", 40'(out_inst), 40'h02);
    applyStimulus(1);
    checkOutput("bp_rel3", 40'(out_pc), 40'h03);

    $display("[TB] redirect");
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(4);
    out_ready = 1'b0;
    applyStimulus(1);
    checkOutput("rd_pre_valid", 40'(out_valid), 40'd1);
    checkOutput("rd_pre_head", 40'(out_pc), 40'h03);
    checkOutput("rd_pre_pc", 40'(inst_address), 40'h05);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    out_ready      = 1'b1;
    applyStimulus(1);
    redirect_valid = 1'b0;
    checkOutput("rd_flush_valid", 40'(out_valid), 40'd0);
    checkOutput("rd_target_addr", 40'(inst_address), 40'h80);
    applyStimulus(1);
    checkOutput("rd_first_valid", 40'(out_valid), 40'd1);
    checkOutput("rd_first_pc", 40'(out_pc), 40'h80);
    applyStimulus(1);
    checkOutput("rd_second_pc", 40'(out_pc), 40'h81);

    $display("[TB] halt");
    mem[4] = {6'h3F, 26'd0};
    start  = 1'b1;
    applyStimulus(1);
    start = 1'b0;
    applyStimulus(4);
    checkOutput("halt_pre_busy", 40'(busy), 40'd1);
    checkOutput("halt_pre_pc3", 40'(out_pc), 40'h03);
    applyStimulus(1);
    checkOutput("halt_halted", 40'(halted), 40'd1);
    checkOutput("halt_busy", 40'(busy), 40'd0);
    checkOutput("halt_head", 40'(out_pc), 40'h04);
    checkOutput("halt_inst", 40'(out_inst), 40'hFC00_0000);
    checkOutput("halt_pc", 40'(inst_address), 40'h05);
    applyStimulus(1);
    checkOutput("halt_drained", 40'(out_valid), 40'd0);
    applyStimulus(2);
    checkOutput("halt_frozen_pc", 40'(inst_address), 40'h05);
    checkOutput("halt_still", 40'(halted), 40'd1);
    checkOutput("halt_empty", 40'(out_valid), 40'd0);
    mem[4] = {6'h00, 26'd4};

    $display("[TB] wrap and reset");
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    applyStimulus(1);
    redirect_valid = 1'b0;
    checkOutput("wrap_busy", 40'(busy), 40'd1);
    checkOutput("wrap_unhalt", 40'(halted), 40'd0);
    applyStimulus(1);
    checkOutput("wrap_fe", 40'(out_pc), 40'hFE);
    applyStimulus(1);
    checkOutput("wrap_ff", 40'(out_pc), 40'hFF);
    checkOutput("wrap_ff_inst", 40'(out_inst), 40'hFF);
    applyStimulus(1);
    checkOutput("wrap_00", 40'(out_pc), 40'h00);
    applyStimulus(1);
    checkOutput("wrap_01", 40'(out_pc), 40'h01);
    checkOutput("wrap_01_valid", 40'(out_valid), 40'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 40'(out_valid), 40'd0);
    checkOutput("async_rst_busy", 40'(busy), 40'd0);
    checkOutput("async_rst_addr", 40'(inst_address), 40'h00);
    #2;
    rst_n = 1'b1;
    applyStimulus(2);
    checkOutput("post_rst_idle", 40'(busy), 40'd0);
    checkOutput("post_rst_empty", 40'(out_valid), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
